// File: rtl/calc_pkg.sv
// Shared opcodes, flag bit positions and default operand width for the calculator datapath.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned FLG_NEG  = 0;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_ERR  = 2;

  function automatic logic [2:0] make_flags(input logic neg, input logic zero, input logic err);
    logic [2:0] f;
    f           = '0;
    f[FLG_NEG]  = neg;
    f[FLG_ZERO] = zero;
    f[FLG_ERR]  = err;
    return f;
  endfunction

endpackage

// File: rtl/calc_seq_alu.sv
// Iterative engine: WIDTH-step shift-add multiply and, with CALC_DIV_EN, restoring divide.
// work_q holds {acc, multiplier} for mul and {remainder, quotient} for div.
module calc_seq_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
`ifdef CALC_DIV_EN
  input  logic               is_div_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [2*WIDTH-1:0]  work_q, work_d;
  logic [2*WIDTH-1:0]  step;
  logic [WIDTH:0]      mul_sum;
  logic                last;
`ifdef CALC_DIV_EN
  logic                div_q, div_d;
  logic [WIDTH:0]      div_shift, div_trial;
`endif

  assign last     = busy_q && (cnt_q == CntW'(WIDTH - 1));
  assign busy_o   = busy_q;
  assign done_o   = last && !abort_i;
  assign result_o = step;

  always_comb begin
    mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    step    = {mul_sum, work_q[WIDTH-1:1]};
`ifdef CALC_DIV_EN
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      // Negative trial means restore: keep the shifted remainder, quotient bit 0.
      if (div_trial[WIDTH]) step = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
      else                  step = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    work_d = work_q;
`ifdef CALC_DIV_EN
    div_d  = div_q;
`endif
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      opnd_d = a_i;
      work_d = {{WIDTH{1'b0}}, b_i};
`ifdef CALC_DIV_EN
      div_d  = is_div_i;
      if (is_div_i) begin
        opnd_d = b_i;
        work_d = {{WIDTH{1'b0}}, a_i};
      end
`endif
    end else if (busy_q) begin
      work_d = step;
      cnt_d  = cnt_q + CntW'(1);
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      work_q <= '0;
`ifdef CALC_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      work_q <= work_d;
`ifdef CALC_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: A/B/FCT registers, single-cycle add/sub, iterative mul/div, result and flags.
// Define CALC_DIV_EN to build the divider; otherwise opcode 11 completes at once with err set.
module calc_datapath
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [1:0]         fct_i,
  input  logic               a_we_i,
  input  logic               a_rst_i,
  input  logic               b_we_i,
  input  logic               b_rst_i,
  input  logic               fct_we_i,
  input  logic               fct_rst_i,
  input  logic               s_we_i,
  input  logic               s_rst_i,
  input  logic               signal_we_i,
  input  logic               signal_rst_i,
  output logic [2*WIDTH-1:0] s_o,
  output logic [2:0]         signal_o,
  output logic               busy_o,
  output logic               done_o
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         fct_q, fct_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [1:0]         fct_sh_q, fct_sh_d;
  logic               swe_sh_q, swe_sh_d;
  logic               pend_q, pend_d;
  logic [2*WIDTH-1:0] s_q, s_d;
  logic [2:0]         flags_q, flags_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum, diff;
  logic               pend_iter, launch, cmpl, neg, err;
  logic [2*WIDTH-1:0] res;
  logic               eng_start, eng_busy, eng_done;
  logic [2*WIDTH-1:0] eng_result;

  always_comb begin
    sum       = {1'b0, a_sh_q} + {1'b0, b_sh_q};
    diff      = {1'b0, a_sh_q} - {1'b0, b_sh_q};
    pend_iter = pend_q && (fct_sh_q == OP_MUL);
`ifdef CALC_DIV_EN
    if (pend_q && (fct_sh_q == OP_DIV) && (b_sh_q != '0)) pend_iter = 1'b1;
`endif
    // An iterative op counts as in flight from its launch edge, so nothing can slip in before busy.
    launch    = s_we_i && !s_rst_i && !eng_busy && !pend_iter;
    eng_start = pend_iter && !s_rst_i;

    cmpl = 1'b0;
    res  = '0;
    neg  = 1'b0;
    err  = 1'b0;
    if (pend_q && !s_rst_i) begin
      unique case (fct_sh_q)
        OP_ADD: begin
          cmpl = 1'b1;
          res  = {{(WIDTH-1){1'b0}}, sum};
        end
        OP_SUB: begin
          cmpl = 1'b1;
          res  = {{(WIDTH-1){diff[WIDTH]}}, diff};
          neg  = diff[WIDTH];
        end
        OP_MUL: cmpl = 1'b0;
        default: begin
          cmpl = !pend_iter;
          err  = !pend_iter;
        end
      endcase
    end
    if (eng_done) begin
      cmpl = 1'b1;
      res  = eng_result;
    end
  end

  always_comb begin
    a_d      = a_rst_i ? '0 : (a_we_i ? data_i : a_q);
    b_d      = b_rst_i ? '0 : (b_we_i ? data_i : b_q);
    fct_d    = fct_rst_i ? '0 : (fct_we_i ? fct_i : fct_q);
    a_sh_d   = launch ? a_q : a_sh_q;
    b_sh_d   = launch ? b_q : b_sh_q;
    fct_sh_d = launch ? fct_q : fct_sh_q;
    swe_sh_d = launch ? signal_we_i : swe_sh_q;
    pend_d   = launch;
    done_d   = cmpl;

    s_d = s_q;
    if (s_rst_i)   s_d = '0;
    else if (cmpl) s_d = res;

    flags_d = flags_q;
    if (signal_rst_i)          flags_d = '0;
    else if (cmpl && swe_sh_q) flags_d = make_flags(neg, res == '0, err);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      fct_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      fct_sh_q <= '0;
      swe_sh_q <= 1'b0;
      pend_q   <= 1'b0;
      s_q      <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      fct_q    <= fct_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      fct_sh_q <= fct_sh_d;
      swe_sh_q <= swe_sh_d;
      pend_q   <= pend_d;
      s_q      <= s_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  calc_seq_alu #(
    .WIDTH(WIDTH)
  ) u_seq_alu (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (eng_start),
    .abort_i  (s_rst_i),
`ifdef CALC_DIV_EN
    .is_div_i (fct_sh_q == OP_DIV),
`endif
    .a_i      (a_sh_q),
    .b_i      (b_sh_q),
    .busy_o   (eng_busy),
    .done_o   (eng_done),
    .result_o (eng_result)
  );

  assign s_o      = s_q;
  assign signal_o = flags_q;
  assign busy_o   = eng_busy;
  assign done_o   = done_q;

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: directed cases with literal expectations, then random traffic
// compared every cycle against a transaction-level model.
module tb_calc_datapath;
  import calc_pkg::*;

  localparam int W = 8;

  logic           clock_i = 1'b0;
  logic           reset_i;
  logic [W-1:0]   data_i;
  logic [1:0]     fct_i;
  logic           a_we_i, a_rst_i, b_we_i, b_rst_i, fct_we_i, fct_rst_i;
  logic           s_we_i, s_rst_i, signal_we_i, signal_rst_i;
  logic [2*W-1:0] s_o;
  logic [2:0]     signal_o;
  logic           busy_o, done_o;

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  calc_datapath #(.WIDTH(W)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .fct_i        (fct_i),
    .a_we_i       (a_we_i),
    .a_rst_i      (a_rst_i),
    .b_we_i       (b_we_i),
    .b_rst_i      (b_rst_i),
    .fct_we_i     (fct_we_i),
    .fct_rst_i    (fct_rst_i),
    .s_we_i       (s_we_i),
    .s_rst_i      (s_rst_i),
    .signal_we_i  (signal_we_i),
    .signal_rst_i (signal_rst_i),
    .s_o          (s_o),
    .signal_o     (signal_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: each launch computes its result with plain arithmetic
  // and a latency; outputs follow from the outstanding transaction.
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [1:0]     m_fct = '0;
  logic [2*W-1:0] m_s = '0, m_res = '0;
  logic [2:0]     m_flags = '0, m_rflags = '0;
  logic           m_busy = 1'b0, m_done = 1'b0, m_inf = 1'b0, m_swe = 1'b0;
  int             m_age = 0, m_lat = 0;

  always @(posedge clock_i) begin : model
    logic           comp, ok, inf, busy;
    logic [2*W-1:0] ea, eb, r, res, s;
    logic [2:0]     fl, rfl, flags;
    int             lat, age;
    logic           swe;
    if (reset_i) begin
      m_a <= '0; m_b <= '0; m_fct <= '0; m_s <= '0; m_flags <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_inf <= 1'b0; m_age <= 0; m_lat <= 0;
      m_res <= '0; m_rflags <= '0; m_swe <= 1'b0;
    end else begin
      comp = 1'b0; inf = m_inf; age = m_age; lat = m_lat;
      res = m_res; rfl = m_rflags; swe = m_swe; s = m_s; flags = m_flags;
      ok = !(m_inf && m_lat > 1);
      if (inf) begin
        if (s_rst_i) inf = 1'b0;
        else begin
          age++;
          if (age == lat) begin comp = 1'b1; inf = 1'b0; end
        end
      end
      if (s_rst_i) s = '0;
      else if (comp) s = m_res;
      if (signal_rst_i) flags = '0;
      else if (comp && m_swe) flags = m_rflags;
      if (s_we_i && !s_rst_i && ok) begin
        ea = {{W{1'b0}}, m_a};
        eb = {{W{1'b0}}, m_b};
        case (m_fct)
          OP_ADD: begin r = ea + eb; lat = 1; fl = {1'b0, r == 0, 1'b0}; end
          OP_SUB: begin r = ea - eb; lat = 1; fl = {1'b0, r == 0, m_a < m_b}; end
          OP_MUL: begin r = ea * eb; lat = W + 1; fl = {1'b0, r == 0, 1'b0}; end
          default: begin
            r = '0; lat = 1; fl = 3'b110;
`ifdef CALC_DIV_EN
            if (m_b != 0) begin
              r = {m_a % m_b, m_a / m_b}; lat = W + 1; fl = {1'b0, r == 0, 1'b0};
            end
`endif
          end
        endcase
        res = r; rfl = fl; age = 0; inf = 1'b1; swe = signal_we_i;
      end
      busy = inf && lat > 1 && age >= 1;
      m_inf <= inf; m_age <= age; m_lat <= lat; m_res <= res; m_rflags <= rfl;
      m_swe <= swe; m_s <= s; m_flags <= flags; m_done <= comp; m_busy <= busy;
      m_a   <= a_rst_i ? '0 : (a_we_i ? data_i : m_a);
      m_b   <= b_rst_i ? '0 : (b_we_i ? data_i : m_b);
      m_fct <= fct_rst_i ? '0 : (fct_we_i ? fct_i : m_fct);
    end
  end

  always @(negedge clock_i) begin
    if (chk_en) begin
      check("model_s", 32'(s_o), 32'(m_s));
      check("model_signal", 32'(signal_o), 32'(m_flags));
      check("model_busy", 32'(busy_o), 32'(m_busy));
      check("model_done", 32'(done_o), 32'(m_done));
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #3;
  endtask

  task automatic idle_inputs();
    data_i = '0; fct_i = '0;
    a_we_i = 0; a_rst_i = 0; b_we_i = 0; b_rst_i = 0; fct_we_i = 0; fct_rst_i = 0;
    s_we_i = 0; s_rst_i = 0; signal_we_i = 0; signal_rst_i = 0;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    a_we_i = 1; data_i = a; tick(); a_we_i = 0;
    b_we_i = 1; data_i = b; tick(); b_we_i = 0;
    fct_we_i = 1; fct_i = f; tick(); fct_we_i = 0;
  endtask

  task automatic launch(input logic swe);
    s_we_i = 1; signal_we_i = swe; tick(); s_we_i = 0; signal_we_i = 0;
  endtask

  task automatic chk_out(input string name, input logic [2*W-1:0] s, input logic [2:0] sig,
                         input logic busy, input logic done);
    check({name, "_s"}, 32'(s_o), 32'(s));
    check({name, "_signal"}, 32'(signal_o), 32'(sig));
    check({name, "_busy"}, 32'(busy_o), 32'(busy));
    check({name, "_done"}, 32'(done_o), 32'(done));
  endtask

  initial begin
    idle_inputs();
    reset_i = 1;
    tick(); tick();
    chk_en = 1'b1;
    chk_out("reset", 16'h0, 3'b000, 0, 0);
    reset_i = 0;

    load(8'd25, 8'd17, OP_ADD); launch(1);
    check("add_no_busy", 32'(busy_o), 32'd0);
    tick(); chk_out("add", 16'd42, 3'b000, 0, 1);
    tick(); check("add_done_once", 32'(done_o), 32'd0);

    load(8'd5, 8'd9, OP_SUB); launch(1);
    tick(); chk_out("sub_neg", 16'hFFFC, 3'b001, 0, 1);
    load(8'd9, 8'd9, OP_SUB); launch(1);
    tick(); chk_out("sub_zero", 16'h0000, 3'b010, 0, 1);

    load(8'd200, 8'd150, OP_MUL); launch(1);
    for (int i = 1; i <= W; i++) begin
      if (i == 3) begin s_we_i = 1; fct_i = OP_ADD; end
      tick();
      s_we_i = 0;
      check("mul_busy", 32'(busy_o), 32'd1);
      check("mul_no_done", 32'(done_o), 32'd0);
    end
    tick(); chk_out("mul", 16'h7530, 3'b000, 0, 1);

`ifdef CALC_DIV_EN
    load(8'd200, 8'd7, OP_DIV); launch(1);
    for (int i = 1; i <= W; i++) begin
      tick(); check("div_busy", 32'(busy_o), 32'd1);
    end
    tick(); chk_out("div", 16'h041C, 3'b000, 0, 1);
`else
    load(8'd200, 8'd7, OP_DIV); launch(1);
    tick(); chk_out("div_absent", 16'h0000, 3'b110, 0, 1);
`endif
    load(8'd200, 8'd0, OP_DIV); launch(1);
    tick(); chk_out("div_by_zero", 16'h0000, 3'b110, 0, 1);

    load(8'd200, 8'd150, OP_MUL); launch(1);
    tick(); tick(); tick();
    check("abort_busy_before", 32'(busy_o), 32'd1);
    s_rst_i = 1; tick(); s_rst_i = 0;
    chk_out("abort", 16'h0000, 3'b110, 0, 0);
    for (int i = 0; i < W + 2; i++) begin
      tick(); check("abort_no_done", 32'(done_o), 32'd0);
    end

    load(8'd200, 8'd150, OP_MUL); launch(1);
    tick(); tick(); tick(); tick();
    reset_i = 1; tick(); reset_i = 0;
    chk_out("reset_mid_mul", 16'h0000, 3'b000, 0, 0);
    launch(1);
    tick(); chk_out("after_reset_add", 16'h0000, 3'b010, 0, 1);

    a_we_i = 1; a_rst_i = 1; data_i = 8'd77; tick(); a_we_i = 0; a_rst_i = 0;
    b_we_i = 1; data_i = 8'd3; tick(); b_we_i = 0;
    fct_we_i = 1; fct_i = OP_ADD; tick(); fct_we_i = 0;
    launch(1);
    tick(); chk_out("a_rst_wins", 16'd3, 3'b000, 0, 1);

    load(8'd5, 8'd9, OP_SUB); launch(1);
    signal_rst_i = 1; tick(); signal_rst_i = 0;
    chk_out("sig_rst_wins", 16'hFFFC, 3'b000, 0, 1);

    for (int i = 0; i < 600; i++) begin
      reset_i      = ($urandom_range(0, 149) == 0);
      data_i       = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      fct_i        = 2'($urandom);
      a_we_i       = ($urandom_range(0, 2) == 0);
      a_rst_i      = ($urandom_range(0, 19) == 0);
      b_we_i       = ($urandom_range(0, 2) == 0);
      b_rst_i      = ($urandom_range(0, 19) == 0);
      fct_we_i     = ($urandom_range(0, 2) == 0);
      fct_rst_i    = ($urandom_range(0, 19) == 0);
      s_we_i       = ($urandom_range(0, 2) == 0);
      s_rst_i      = ($urandom_range(0, 39) == 0);
      signal_we_i  = ($urandom_range(0, 1) == 1);
      signal_rst_i = ($urandom_range(0, 24) == 0);
      tick();
    end
    idle_inputs();
    reset_i = 0;
    for (int i = 0; i < W + 3; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_datapath.md
CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width; the result is 2*WIDTH bits.
REQ-002 SHALL have port: clock_i  in  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: reset_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: data_i  in  WIDTH  shared operand bus, loaded into A or B.
REQ-005 SHALL have port: fct_i  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have ports: a_we_i, a_rst_i, b_we_i, b_rst_i, fct_we_i, fct_rst_i  in  1 each  register write enables and clears, driven by the control FSM.
REQ-007 SHALL have ports: s_we_i, s_rst_i, signal_we_i, signal_rst_i  in  1 each  s_we_i launches the operation; signal_we_i enables flag update; the *_rst_i inputs clear the register.
REQ-008 SHALL have port: s_o  out  2*WIDTH  result register S.
REQ-009 SHALL have port: signal_o  out  3  flags: bit0 neg, bit1 zero, bit2 err.
REQ-010 SHALL have ports: busy_o, done_o  out  1 each  busy_o marks an iterative op in flight; done_o is a one-cycle completion pulse.

Function
REQ-011 SHALL implement A, B and FCT registers that clear on *_rst_i and load data_i/fct_i on *_we_i; rst wins over we on the same edge.
REQ-012 SHALL, on an edge with s_we_i=1 and busy_o=0, snapshot A, B, FCT and signal_we_i as the launch operands.
REQ-013 SHALL, for add, update S and the flags at the launch edge plus 1, with done_o=1 for that one cycle and busy_o never asserted.
REQ-014 SHALL, for sub, behave like add with the same latency; S = A-B sign-extended to 2*WIDTH bits, with neg=1 when A<B.
REQ-015 SHALL compute mul as an unsigned shift-add over WIDTH iterations.
REQ-016 SHALL hold busy_o=1 from launch+1 through launch+WIDTH for mul and div, then update S and flags and pulse done_o at launch+WIDTH+1 with busy_o=0.
REQ-017 SHALL compute div as unsigned restoring division: S[WIDTH-1:0]=quotient, S[2W-1:W]=remainder.
REQ-018 SHALL complete div with B=0 in 1 edge: S=0, err=1, busy_o never asserted.
REQ-019 SHALL set the zero flag when the final S equals 0.
REQ-020 SHALL clear err on every completion except an error completion.
REQ-021 SHALL write the flags at completion only if the captured signal_we_i was 1; S is always written.
REQ-022 SHALL ignore s_we_i while busy_o=1.
REQ-023 SHALL let writes to A, B and FCT during busy load the registers without affecting the running op.
REQ-024 SHALL, on s_rst_i while busy, abort: S=0 and busy_o=0 at the next edge, no done_o, flags untouched.
REQ-025 SHALL, when signal_rst_i coincides with a completion, clear the flags (rst wins) while still writing S.

Reset
REQ-026 SHALL, on reset_i=1, set A, B, FCT, S, SIGNAL, busy_o, done_o, the iteration counter and the shadow operands to 0 at the next edge, aborting any op.
REQ-027 SHALL give reset_i priority over every *_we_i and *_rst_i.

Configuration
REQ-028 SHALL, with CALC_DIV_EN defined, implement div as in REQ-017/018.
REQ-029 SHALL, without CALC_DIV_EN, complete opcode 11 in 1 edge with S=0 and err=1, and omit the divider logic.

Structure
REQ-030 SHALL place in package calc_pkg: opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_DIV), flag bit indices (FLG_NEG, FLG_ZERO, FLG_ERR) and the default WIDTH.
REQ-031 SHALL place the iterative mul/div engine (counter, partial remainder/product, start/abort/done) in sub-module calc_seq_alu; add/sub stays in calc_datapath.

Verification
REQ-032 SHALL cover add: A=25, B=17 -> S=42 one edge after launch; flags 000; one done pulse; busy_o stays 0.
REQ-033 SHALL cover sub: A=5, B=9 -> S=0xFFFC, neg=1; then A=9, B=9 -> S=0, zero=1.
REQ-034 SHALL cover mul: A=200, B=150 -> busy_o high 8 cycles; S=0x7530 with done at launch+9; s_we_i pulsed mid-busy is ignored.
REQ-035 SHALL cover div: A=200, B=7 -> S=0x041C at launch+9; B=0 -> S=0, err=1 after 1 edge; build without CALC_DIV_EN -> opcode 11 gives err=1.
REQ-036 SHALL cover abort: s_rst_i 3 cycles into mul -> S=0, busy_o=0 next edge, no done; reset_i mid-mul -> all outputs 0.
REQ-037 SHALL cover priorities: a_we_i with a_rst_i -> A=0; signal_rst_i at a completion edge -> flags 000, S updated.
